// File: rtl/seg7_pkg.sv
// Shared types for the multiplexed 7-segment scan controller.
package seg7_pkg;

  localparam int unsigned CodeW = 3;

  typedef enum logic [1:0] {
    StIdle,
    StShow,
    StGap
  } state_e;

  typedef struct packed {
    logic [CodeW-1:0] value;
    logic             blank;
  } digit_t;

endpackage

// File: rtl/seg7_dwell_timer.sv
// Loadable down-counter; tc_o is high while the count sits at zero, which marks the
// last cycle of a loaded interval.
module seg7_dwell_timer #(
  parameter int unsigned CntW = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  output logic            tc_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/seg7_scan_controller.sv
// Time-multiplexes per-digit 3-bit codes onto one shared decoder, with a blanked gap
// between digits and a tear-free write port into the digit register file.
module seg7_scan_controller
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DWELL_CYCLES = 50000,
  parameter int unsigned GAP_CYCLES   = 500,
  localparam int unsigned IDXW        = $clog2(NUM_DIGITS)
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET,
  input  logic                  enable,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [IDXW-1:0]       wr_index,
  input  logic [CodeW-1:0]      wr_value,
  input  logic                  wr_blank,
  output logic [CodeW-1:0]      dec_code,
  output logic                  seg_blank,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic [IDXW-1:0]       cur_digit,
  output logic                  frame_tick
);

  localparam int unsigned MaxCyc = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);
  localparam logic [CntW-1:0] DwellLoad = CntW'(DWELL_CYCLES - 1);
  localparam logic [CntW-1:0] GapLoad   = CntW'(GAP_CYCLES - 1);
  localparam logic [IDXW-1:0] LastDigit = IDXW'(NUM_DIGITS - 1);

  state_e                state_q, state_d;
  logic [IDXW-1:0]       cur_q, cur_d;
  digit_t                digits_q [NUM_DIGITS];
  digit_t                digits_d [NUM_DIGITS];
  logic [CodeW-1:0]      dec_code_q, dec_code_d;
  logic                  seg_blank_q, seg_blank_d;
  logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
  logic                  frame_tick_q, frame_tick_d;

  logic            advance;
  logic            tmr_clr, tmr_load, tmr_tc;
  logic [CntW-1:0] tmr_load_val;
  logic            wr_in_range, wr_accept;
  digit_t          shown;

  // Never rewrite the digit currently driving the segments.
  assign wr_ready    = !((state_q == StShow) && (wr_index == cur_q));
  assign wr_in_range = ({1'b0, wr_index} < (IDXW + 1)'(NUM_DIGITS));
  assign wr_accept   = wr_valid && wr_ready && wr_in_range;

  always_comb begin
    digits_d = digits_q;
    if (wr_accept) begin
      digits_d[wr_index] = '{value: wr_value, blank: wr_blank};
    end
  end

  seg7_dwell_timer #(
    .CntW(CntW)
  ) u_timer (
    .clk_i      (CLOCK_50),
    .rst_i      (RESET),
    .clr_i      (tmr_clr),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .tc_o       (tmr_tc)
  );

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q      <= StIdle;
      cur_q        <= '0;
      dec_code_q   <= '0;
      seg_blank_q  <= 1'b1;
      digit_sel_q  <= '0;
      frame_tick_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        digits_q[i] <= '{value: '0, blank: 1'b1};
      end
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      dec_code_q   <= dec_code_d;
      seg_blank_q  <= seg_blank_d;
      digit_sel_q  <= digit_sel_d;
      frame_tick_q <= frame_tick_d;
      digits_q     <= digits_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    advance      = 1'b0;
    tmr_clr      = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = DwellLoad;
    if (!enable) begin
      state_d = StIdle;
      cur_d   = '0;
      tmr_clr = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d  = StShow;
          cur_d    = '0;
          tmr_load = 1'b1;
        end
        StShow: begin
          if (tmr_tc) begin
            tmr_load = 1'b1;
            if (GAP_CYCLES > 0) begin
              state_d      = StGap;
              tmr_load_val = GapLoad;
            end else begin
              advance = 1'b1;
            end
          end
        end
        StGap: begin
          if (tmr_tc) begin
            state_d  = StShow;
            tmr_load = 1'b1;
            advance  = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
      if (advance) begin
        cur_d = (cur_q == LastDigit) ? '0 : cur_q + IDXW'(1);
      end
    end
  end

  // Reading digits_d lets a write landing on the advance edge show immediately.
  always_comb begin
    shown        = digits_d[cur_d];
    digit_sel_d  = '0;
    seg_blank_d  = 1'b1;
    dec_code_d   = dec_code_q;
    frame_tick_d = advance && (cur_q == LastDigit);
    if (state_d == StShow) begin
      digit_sel_d = NUM_DIGITS'(1) << cur_d;
      dec_code_d  = shown.value;
      seg_blank_d = shown.blank;
    end
  end

  assign dec_code   = dec_code_q;
  assign seg_blank  = seg_blank_q;
  assign digit_sel  = digit_sel_q;
  assign cur_digit  = cur_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Scoreboard bench: stimulus pushes one expected output vector per cycle, a negedge
// monitor pops and compares. DUT A: 4 digits, dwell 4, gap 2. DUT B: 5 digits, no gap.
module tb_seg7_scan_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, en_a, wv_a, rdy_a, wb_a, blank_a, tick_a;
  logic [1:0] wi_a, cur_a;
  logic [2:0] wval_a, code_a;
  logic [3:0] sel_a;

  logic       rst_b, en_b, wv_b, rdy_b, wb_b, blank_b, tick_b;
  logic [2:0] wi_b, cur_b;
  logic [2:0] wval_b, code_b;
  logic [4:0] sel_b;

  seg7_scan_controller #(
    .NUM_DIGITS  (4),
    .DWELL_CYCLES(4),
    .GAP_CYCLES  (2)
  ) u_dut_a (
    .CLOCK_50  (clk),
    .RESET     (rst_a),
    .enable    (en_a),
    .wr_valid  (wv_a),
    .wr_ready  (rdy_a),
    .wr_index  (wi_a),
    .wr_value  (wval_a),
    .wr_blank  (wb_a),
    .dec_code  (code_a),
    .seg_blank (blank_a),
    .digit_sel (sel_a),
    .cur_digit (cur_a),
    .frame_tick(tick_a)
  );

  seg7_scan_controller #(
    .NUM_DIGITS  (5),
    .DWELL_CYCLES(4),
    .GAP_CYCLES  (0)
  ) u_dut_b (
    .CLOCK_50  (clk),
    .RESET     (rst_b),
    .enable    (en_b),
    .wr_valid  (wv_b),
    .wr_ready  (rdy_b),
    .wr_index  (wi_b),
    .wr_value  (wval_b),
    .wr_blank  (wb_b),
    .dec_code  (code_b),
    .seg_blank (blank_b),
    .digit_sel (sel_b),
    .cur_digit (cur_b),
    .frame_tick(tick_b)
  );

  typedef struct {
    string      tag;
    logic [7:0] sel;
    logic [2:0] code;
    bit         cchk;
    logic       blank;
    logic       tick;
    logic [2:0] cur;
    logic       rdy;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input exp_t e, input logic [7:0] sel, input logic [2:0] code,
                       input logic blank, input logic tick, input logic [2:0] cur,
                       input logic rdy);
    checks++;
    if (sel !== e.sel || (e.cchk && code !== e.code) || blank !== e.blank ||
        tick !== e.tick || cur !== e.cur || rdy !== e.rdy) begin
      failures++;
      $display("FAIL %s @%0t: got sel=%b code=%0d blank=%b tick=%b cur=%0d rdy=%b, want sel=%b code=%0d(chk=%0d) blank=%b tick=%b cur=%0d rdy=%b",
               e.tag, $time, sel, code, blank, tick, cur, rdy,
               e.sel, e.code, e.cchk, e.blank, e.tick, e.cur, e.rdy);
    end
  endtask

  always @(negedge clk) begin
    if (qa.size() > 0) check(qa.pop_front(), {4'b0, sel_a}, code_a, blank_a, tick_a,
                             {1'b0, cur_a}, rdy_a);
    if (qb.size() > 0) check(qb.pop_front(), {3'b0, sel_b}, code_b, blank_b, tick_b,
                             cur_b, rdy_b);
  end

  task automatic expect_cyc(input int dut, input string tag, input logic [7:0] sel,
                            input logic [2:0] code, input bit cchk, input logic blank,
                            input logic tick, input logic [2:0] cur, input logic rdy);
    exp_t e;
    e.tag = tag; e.sel = sel; e.code = code; e.cchk = cchk;
    e.blank = blank; e.tick = tick; e.cur = cur; e.rdy = rdy;
    if (dut == 0) qa.push_back(e);
    else          qb.push_back(e);
  endtask

  task automatic idle(input int dut, input string tag, input logic [2:0] code,
                      input bit cchk);
    expect_cyc(dut, tag, 8'h00, code, cchk, 1'b1, 1'b0, 3'd0, 1'b1);
  endtask

  // Expected outputs for one scan frame (dwell of 4); vals packs 3 bits per digit.
  task automatic push_frame(input int dut, input string tag, input bit first,
                            input logic [23:0] vals, input logic [7:0] blks, input int n,
                            input int gap, input int idx, input int limit);
    int cnt = 0;
    for (int d = 0; d < n; d++) begin
      for (int j = 0; j < 4; j++) begin
        if (cnt < limit)
          expect_cyc(dut, tag, 8'(1) << d, vals[3*d +: 3], 1'b1, blks[d],
                     !first && d == 0 && j == 0, 3'(d), idx != d);
        cnt++;
      end
      for (int g = 0; g < gap; g++) begin
        if (cnt < limit)
          expect_cyc(dut, tag, 8'h00, vals[3*d +: 3], 1'b1, 1'b1, 1'b0, 3'(d), 1'b1);
        cnt++;
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_a(input logic [1:0] idx, input logic [2:0] val, input logic blk);
    wv_a = 1'b1; wi_a = idx; wval_a = val; wb_a = blk;
    idle(0, "wr_a_idle", 3'd0, 1'b1);
    run(1);
  endtask

  task automatic write_b(input logic [2:0] idx, input logic [2:0] val, input logic blk);
    wv_b = 1'b1; wi_b = idx; wval_b = val; wb_b = blk;
    idle(1, "wr_b_idle", 3'd0, 1'b1);
    run(1);
  endtask

  localparam logic [23:0] ValsA0 = {12'd0, 3'd0, 3'd7, 3'd2, 3'd5};
  localparam logic [23:0] ValsA1 = {12'd0, 3'd0, 3'd7, 3'd3, 3'd5};
  localparam logic [23:0] ValsA2 = {12'd0, 3'd0, 3'd7, 3'd3, 3'd6};
  localparam logic [23:0] ValsB  = {9'd0, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_a = 1'b1; en_a = 1'b0; wv_a = 1'b0; wi_a = '0; wval_a = '0; wb_a = 1'b0;
    rst_b = 1'b1; en_b = 1'b0; wv_b = 1'b0; wi_b = '0; wval_b = '0; wb_b = 1'b0;
    run(2);
    idle(0, "reset_state", 3'd0, 1'b1);
    run(1);
    rst_a = 1'b0;

    write_a(2'd0, 3'd5, 1'b0);
    write_a(2'd1, 3'd2, 1'b0);
    write_a(2'd2, 3'd7, 1'b0);
    write_a(2'd3, 3'd0, 1'b0);
    wv_a = 1'b0; wi_a = 2'd1;

    en_a = 1'b1;
    idle(0, "pre_scan", 3'd0, 1'b1);
    push_frame(0, "scan_f1", 1'b1, ValsA0, 8'h00, 4, 2, 1, 99);
    run(25);

    // Digit 1 write must stall through its SHOW and land in the following gap.
    push_frame(0, "stall_f2", 1'b0, ValsA0, 8'h00, 4, 2, 1, 99);
    run(6);
    wv_a = 1'b1; wval_a = 3'd3; wb_a = 1'b0;
    run(5);
    wv_a = 1'b0;
    run(13);
    push_frame(0, "stall_f3", 1'b0, ValsA1, 8'h00, 4, 2, 1, 99);
    run(24);

    // Drop enable during digit 2 SHOW together with an accepted write to digit 0.
    push_frame(0, "drop_f4", 1'b0, ValsA1, 8'h00, 4, 2, 1, 15);
    idle(0, "drop_idle", 3'd0, 1'b0);
    run(14);
    en_a = 1'b0; wv_a = 1'b1; wi_a = 2'd0; wval_a = 3'd6; wb_a = 1'b0;
    run(2);
    wi_a = 2'd2; wval_a = 3'd7; wb_a = 1'b1;
    idle(0, "idle_wr", 3'd0, 1'b0);
    run(1);
    wv_a = 1'b0;
    idle(0, "idle_hold", 3'd0, 1'b0);
    run(1);
    en_a = 1'b1;
    idle(0, "resume_idle", 3'd0, 1'b0);
    push_frame(0, "resume_blank", 1'b1, ValsA2, 8'b0000_0100, 4, 2, 2, 99);
    run(25);

    // Asynchronous reset mid-SHOW; enable stays high throughout.
    push_frame(0, "pre_reset", 1'b0, ValsA2, 8'b0000_0100, 4, 2, 2, 2);
    run(2);
    rst_a = 1'b1;
    idle(0, "async_reset", 3'd0, 1'b1);
    run(1);
    idle(0, "reset_held", 3'd0, 1'b1);
    run(1);
    rst_a = 1'b0;
    idle(0, "post_reset_idle", 3'd0, 1'b1);
    push_frame(0, "post_reset_scan", 1'b1, 24'd0, 8'hFF, 4, 2, 2, 99);
    run(25);

    // DUT B: no gap state, non-power-of-two digit count, out-of-range writes.
    idle(1, "b_reset", 3'd0, 1'b1);
    run(1);
    rst_b = 1'b0;
    for (int d = 0; d < 5; d++) write_b(3'(d), 3'(d + 1), 1'b0);
    write_b(3'd5, 3'd7, 1'b1);
    write_b(3'd7, 3'd6, 1'b1);
    wv_b = 1'b0; wi_b = 3'd7;
    en_b = 1'b1;
    idle(1, "b_pre_scan", 3'd0, 1'b1);
    push_frame(1, "b_scan_f1", 1'b1, ValsB, 8'h00, 5, 0, 7, 99);
    push_frame(1, "b_scan_f2", 1'b0, ValsB, 8'h00, 5, 0, 7, 99);
    run(41);

    for (int i = 0; i < 10 && (qa.size() > 0 || qb.size() > 0); i++) run(1);
    if (qa.size() > 0 || qb.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d/%0d expected vectors left unchecked, want 0/0",
               qa.size(), qb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
